pmt_uart_tx_scheduler: RTL and testbench

- Sequences the PMT UART transmitter: buffers per-timebin PMT1/PMT2 counts and formats each into a one- or two-byte frame.
- Shares the transmitter between count frames and the timebin-factor report.
- Drives the UART transmit/tx_byte/TwoBytes inputs and waits on its is_transmitting/tx_Done outputs.
- Sits between the timebin counter logic and the uart block.

---
 rtl/pmt_uart_pkg.sv | 28 ++
 rtl/pmt_uart_tx_scheduler_if.sv | 22 ++
 rtl/count_fifo.sv | 57 +++++
 rtl/pmt_uart_tx_scheduler.sv | 167 ++++++++++++++++
 tb/tb_pmt_uart_tx_scheduler.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pmt_uart_pkg.sv
// Shared types and constants for the PMT UART transmit scheduler.
// A count byte saturates at COUNT_MAX so that 8'hFE and 8'hFF stay free for frame headers.
package pmt_uart_pkg;

  typedef enum logic [1:0] {
    MODE_PMT1 = 2'd0,
    MODE_PMT2 = 2'd1,
    MODE_SUM  = 2'd2,
    MODE_BOTH = 2'd3
  } mode_e;

  typedef enum logic [2:0] {
    IDLE,
    LOAD_TB,
    LOAD_CNT,
    ISSUE,
    WAIT_DONE
  } state_e;

  localparam logic [7:0] TB_HEADER = 8'hFE;
  localparam logic [7:0] COUNT_MAX = 8'hFD;

  // The argument is 9 bits wide so the carry out of a PMT1+PMT2 sum still saturates.
  function automatic logic [7:0] sat_count(input logic [8:0] value, input logic [7:0] ceiling);
    return (value > {1'b0, ceiling}) ? ceiling : value[7:0];
  endfunction

endpackage

// File: rtl/pmt_uart_tx_scheduler_if.sv
// Handshake between the scheduler (master) and the UART transmitter (slave).
// uart_byte[7:0] goes on the line first; uart_two_bytes selects a two-byte frame.
interface pmt_uart_tx_scheduler_if;
  import pmt_uart_pkg::*;

  logic        uart_transmit;
  logic [15:0] uart_byte;
  logic        uart_two_bytes;
  logic        uart_busy;
  logic        uart_done;

  modport master (
    output uart_transmit, uart_byte, uart_two_bytes,
    input  uart_busy, uart_done
  );

  modport slave (
    input  uart_transmit, uart_byte, uart_two_bytes,
    output uart_busy, uart_done
  );

endinterface

// File: rtl/count_fifo.sv
// Single-clock show-ahead FIFO holding {pmt2, pmt1} count records.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module count_fifo
#(
  parameter int FIFO_DEPTH = 16,
  parameter int ADDR_W     = 4,
  parameter int WIDTH      = 16
)
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic              i_pop,
  input  logic [WIDTH-1:0]  i_wdata,
  output logic [WIDTH-1:0]  o_rdata,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_level
);
  import pmt_uart_pkg::*;

  logic [WIDTH-1:0]  r_mem [FIFO_DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_level;
  logic              w_wr;
  logic              w_rd;

  assign o_full  = (r_level == (ADDR_W + 1)'(FIFO_DEPTH));
  assign o_empty = (r_level == '0);
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rd_ptr];
  assign w_rd    = i_pop && !o_empty;
  assign w_wr    = i_push && (!o_full || w_rd);

  // Pointers wrap naturally because FIFO_DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_rd) r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_wr, w_rd})
        2'b10:   r_level <= r_level + (ADDR_W + 1)'(1);
        2'b01:   r_level <= r_level - (ADDR_W + 1)'(1);
        default: r_level <= r_level;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule

// File: rtl/pmt_uart_tx_scheduler.sv
// Buffers per-timebin PMT counts and shares one UART between count frames and the
// timebin-factor report; a pending timebin report always wins arbitration in IDLE.
module pmt_uart_tx_scheduler
#(
  parameter int         FIFO_DEPTH    = 16,
  parameter int         ADDR_W        = 4,
  parameter logic [7:0] TB_HEADER     = 8'hFE,
  parameter logic [7:0] COUNT_MAX     = 8'hFD,
  parameter int         ISSUE_TIMEOUT = 1023
)
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_bin_valid,
  input  logic [7:0]               i_pmt1_count,
  input  logic [7:0]               i_pmt2_count,
  input  logic [1:0]               i_mode,
  input  logic                     i_send_timebin,
  input  logic [7:0]               i_timebin_factor,
  input  logic                     i_stop,
  pmt_uart_tx_scheduler_if.master  uart,
  output logic [ADDR_W:0]          o_fifo_level,
  output logic [7:0]               o_overflow_count,
  output logic                     o_timeout_err,
  output logic                     o_busy
);
  import pmt_uart_pkg::*;

  localparam int TMR_W = $clog2(ISSUE_TIMEOUT + 1);

  state_e            r_state;
  logic              r_transmit;
  logic [15:0]       r_byte;
  logic              r_two;
  logic              r_is_tb;
  logic              r_tb_pending;
  logic              r_send_q;
  logic              r_send_q2;
  logic              r_timeout_err;
  logic [TMR_W-1:0]  r_timer;
  logic [15:0]       r_rec;
  logic [7:0]        r_overflow;

  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic              w_drop;
  logic              w_tb_edge;
  logic              w_timeout;
  logic [15:0]       w_rdata;
  logic [ADDR_W:0]   w_level;
  logic [7:0]        w_s1;
  logic [7:0]        w_s2;
  logic [7:0]        w_sum;

  assign w_pop     = (r_state == IDLE) && !i_stop && !r_tb_pending && !w_empty;
  assign w_drop    = i_bin_valid && w_full && !w_pop;
  assign w_tb_edge = r_send_q && !r_send_q2;
  assign w_timeout = (r_state == ISSUE) && !uart.uart_busy &&
                     (r_timer == TMR_W'(ISSUE_TIMEOUT - 1));
  assign w_s1      = sat_count({1'b0, r_rec[7:0]}, COUNT_MAX);
  assign w_s2      = sat_count({1'b0, r_rec[15:8]}, COUNT_MAX);
  assign w_sum     = sat_count({1'b0, r_rec[7:0]} + {1'b0, r_rec[15:8]}, COUNT_MAX);

  count_fifo #(
    .FIFO_DEPTH (FIFO_DEPTH),
    .ADDR_W     (ADDR_W),
    .WIDTH      (16)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (i_bin_valid),
    .i_pop   (w_pop),
    .i_wdata ({i_pmt2_count, i_pmt1_count}),
    .o_rdata (w_rdata),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_level (w_level)
  );

  // A timed-out timebin frame is re-armed; a newer button edge also wins over the LOAD_TB clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_send_q     <= 1'b0;
      r_send_q2    <= 1'b0;
      r_tb_pending <= 1'b0;
      r_overflow   <= 8'h00;
    end else begin
      r_send_q  <= i_send_timebin;
      r_send_q2 <= r_send_q;
      if (w_tb_edge || (w_timeout && r_is_tb)) r_tb_pending <= 1'b1;
      else if (r_state == LOAD_TB)             r_tb_pending <= 1'b0;
      if (w_drop && (r_overflow != 8'hFF)) r_overflow <= r_overflow + 8'h01;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_transmit    <= 1'b0;
      r_byte        <= 16'h0000;
      r_two         <= 1'b0;
      r_is_tb       <= 1'b0;
      r_timeout_err <= 1'b0;
      r_timer       <= '0;
      r_rec         <= 16'h0000;
    end else begin
      case (r_state)
        IDLE: begin
          if (!i_stop) begin
            if (r_tb_pending) begin
              r_state <= LOAD_TB;
            end else if (!w_empty) begin
              r_rec   <= w_rdata;
              r_state <= LOAD_CNT;
            end
          end
        end
        LOAD_TB: begin
          r_byte     <= {i_timebin_factor, TB_HEADER};
          r_two      <= 1'b1;
          r_is_tb    <= 1'b1;
          r_timer    <= '0;
          r_transmit <= 1'b1;
          r_state    <= ISSUE;
        end
        LOAD_CNT: begin
          case (mode_e'(i_mode))
            MODE_PMT2: begin r_byte <= {8'h00, w_s2};  r_two <= 1'b0; end
            MODE_SUM:  begin r_byte <= {8'h00, w_sum}; r_two <= 1'b0; end
            MODE_BOTH: begin r_byte <= {w_s2, w_s1};   r_two <= 1'b1; end
            default:   begin r_byte <= {8'h00, w_s1};  r_two <= 1'b0; end
          endcase
          r_is_tb    <= 1'b0;
          r_timer    <= '0;
          r_transmit <= 1'b1;
          r_state    <= ISSUE;
        end
        ISSUE: begin
          if (uart.uart_busy) begin
            r_transmit <= 1'b0;
            r_state    <= WAIT_DONE;
          end else if (w_timeout) begin
            r_transmit    <= 1'b0;
            r_timeout_err <= 1'b1;
            r_state       <= IDLE;
          end else begin
            r_timer <= r_timer + TMR_W'(1);
          end
        end
        WAIT_DONE: begin
          if (uart.uart_done) r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign uart.uart_transmit  = r_transmit;
  assign uart.uart_byte      = r_byte;
  assign uart.uart_two_bytes = r_two;
  assign o_fifo_level        = w_level;
  assign o_overflow_count    = r_overflow;
  assign o_timeout_err       = r_timeout_err;
  assign o_busy              = (r_state != IDLE);

endmodule

// File: tb/tb_pmt_uart_tx_scheduler.sv
// Directed bench: a small UART responder captures every issued frame, and one
// linear initial block checks frames, FIFO state, stop, timeout and reset.
module tb_pmt_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic        binValid;
  logic [7:0]  pmt1Count;
  logic [7:0]  pmt2Count;
  logic [1:0]  mode;
  logic        sendTimebin;
  logic [7:0]  timebinFactor;
  logic        stop;
  logic [4:0]  oFifoLevel;
  logic [7:0]  oOverflowCount;
  logic        oTimeoutErr;
  logic        oBusy;

  int compareCount = 0;
  int failCount    = 0;

  // uartMode: 0 normal (busy after 2 cycles, done after ~40), 1 stalled (no done), 2 never busy
  int          uartMode   = 0;
  logic        uartActive = 1'b0;
  int          uartCnt    = 0;
  int          protoErr   = 0;
  logic [15:0] capByte[$];
  logic        capTwo[$];

  pmt_uart_tx_scheduler_if uif();

  pmt_uart_tx_scheduler dut (
    .clk              (clk),
    .rst              (rst),
    .i_bin_valid      (binValid),
    .i_pmt1_count     (pmt1Count),
    .i_pmt2_count     (pmt2Count),
    .i_mode           (mode),
    .i_send_timebin   (sendTimebin),
    .i_timebin_factor (timebinFactor),
    .i_stop           (stop),
    .uart             (uif.master),
    .o_fifo_level     (oFifoLevel),
    .o_overflow_count (oOverflowCount),
    .o_timeout_err    (oTimeoutErr),
    .o_busy           (oBusy)
  );

  always #10 clk = ~clk;

  // UART responder; also flags transmit not dropping right after busy, or the byte changing mid-frame
  initial begin
    uif.uart_busy = 1'b0;
    uif.uart_done = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      uif.uart_done = 1'b0;
      if (uartActive) begin
        uartCnt++;
        if ((uartCnt == 1 || uartCnt == 2) && uif.uart_transmit !== 1'b1) protoErr++;
        if (uartCnt == 3 && uif.uart_transmit !== 1'b0) protoErr++;
        if (uif.uart_byte !== capByte[capByte.size() - 1]) protoErr++;
        if (uartCnt == 2) uif.uart_busy = 1'b1;
        if (uartCnt >= 42 && uartMode == 0) begin
          uif.uart_busy = 1'b0;
          uif.uart_done = 1'b1;
          uartActive    = 1'b0;
        end
      end else if (uif.uart_transmit === 1'b1 && uartMode != 2) begin
        uartActive = 1'b1;
        uartCnt    = 0;
        capByte.push_back(uif.uart_byte);
        capTwo.push_back(uif.uart_two_bytes);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic [7:0] p1, input logic [7:0] p2);
    binValid  = 1'b1;
    pmt1Count = p1;
    pmt2Count = p2;
    tick(1);
    binValid  = 1'b0;
  endtask

  task automatic waitQuiet(input int maxCycles);
    int   n;
    logic ok;
    n  = 0;
    ok = 1'b0;
    while (n < maxCycles && !ok) begin
      tick(1);
      n++;
      if (!oBusy && oFifoLevel == 5'd0 && !uartActive) ok = 1'b1;
    end
    checkOutput("quiet_reached", 32'(ok), 32'd1);
  endtask

  task automatic checkFrame(input string tag, input int idx, input logic [15:0] eb, input logic et);
    if (idx < capByte.size()) begin
      checkOutput({tag, "_byte"}, 32'(capByte[idx]), 32'(eb));
      checkOutput({tag, "_two"}, 32'(capTwo[idx]), 32'(et));
    end else begin
      checkOutput({tag, "_present"}, 32'(capByte.size()), 32'(idx + 1));
    end
  endtask

  task automatic runFrame(input string tag, input logic [1:0] m, input logic [7:0] p1,
                          input logic [7:0] p2, input logic [15:0] eb, input logic et);
    int b;
    b    = capByte.size();
    mode = m;
    applyStimulus(p1, p2);
    waitQuiet(300);
    checkFrame(tag, b, eb, et);
    checkOutput({tag, "_count"}, 32'(capByte.size()), 32'(b + 1));
  endtask

  initial begin
    int b;
    rst           = 1'b1;
    binValid      = 1'b0;
    pmt1Count     = 8'h00;
    pmt2Count     = 8'h00;
    mode          = 2'd0;
    sendTimebin   = 1'b0;
    timebinFactor = 8'h00;
    stop          = 1'b0;
    tick(3);

    $display("[TB] reset values");
    checkOutput("rst_transmit", 32'(uif.uart_transmit), 32'd0);
    checkOutput("rst_byte", 32'(uif.uart_byte), 32'd0);
    checkOutput("rst_two", 32'(uif.uart_two_bytes), 32'd0);
    checkOutput("rst_level", 32'(oFifoLevel), 32'd0);
    checkOutput("rst_ovf", 32'(oOverflowCount), 32'd0);
    checkOutput("rst_busy", 32'(oBusy), 32'd0);
    rst = 1'b0;
    tick(2);

    $display("[TB] mode 3 frame and latency");
    b    = capByte.size();
    mode = 2'd3;
    applyStimulus(8'h12, 8'h34);
    checkOutput("lat_c0_transmit", 32'(uif.uart_transmit), 32'd0);
    checkOutput("lat_c0_level", 32'(oFifoLevel), 32'd1);
    tick(1);
    checkOutput("lat_c1_transmit", 32'(uif.uart_transmit), 32'd0);
    checkOutput("lat_c1_busy", 32'(oBusy), 32'd1);
    tick(1);
    checkOutput("lat_c2_transmit", 32'(uif.uart_transmit), 32'd1);
    checkOutput("lat_c2_byte", 32'(uif.uart_byte), 32'h3412);
    checkOutput("lat_c2_two", 32'(uif.uart_two_bytes), 32'd1);
    waitQuiet(300);
    checkFrame("both", b, 16'h3412, 1'b1);
    checkOutput("both_count", 32'(capByte.size()), 32'(b + 1));

    $display("[TB] saturation");
    runFrame("sum_sat", 2'd2, 8'hF0, 8'h20, 16'h00FD, 1'b0);
    runFrame("sum_plain", 2'd2, 8'h10, 8'h20, 16'h0030, 1'b0);
    runFrame("sum_edge", 2'd2, 8'h7F, 8'h7E, 16'h00FD, 1'b0);
    runFrame("pmt1_sat", 2'd0, 8'hFF, 8'h01, 16'h00FD, 1'b0);
    runFrame("pmt2_plain", 2'd1, 8'h05, 8'h09, 16'h0009, 1'b0);
    runFrame("both_sat", 2'd3, 8'hFE, 8'hFF, 16'hFDFD, 1'b1);

    $display("[TB] timebin priority and merge");
    b             = capByte.size();
    mode          = 2'd3;
    timebinFactor = 8'h07;
    applyStimulus(8'h01, 8'h02);
    tick(10);
    applyStimulus(8'h03, 8'h04);
    sendTimebin = 1'b1;
    tick(3);
    sendTimebin = 1'b0;
    tick(3);
    sendTimebin = 1'b1;
    tick(3);
    sendTimebin = 1'b0;
    waitQuiet(500);
    checkFrame("tb_first", b, 16'h0201, 1'b1);
    checkFrame("tb_frame", b + 1, 16'h07FE, 1'b1);
    checkFrame("tb_after", b + 2, 16'h0403, 1'b1);
    checkOutput("tb_count", 32'(capByte.size()), 32'(b + 3));

    $display("[TB] overflow with stalled uart");
    b        = capByte.size();
    mode     = 2'd0;
    uartMode = 1;
    applyStimulus(8'h50, 8'h00);
    tick(10);
    for (int i = 1; i <= 17; i++) applyStimulus(8'(i), 8'h00);
    checkOutput("ovf_level", 32'(oFifoLevel), 32'd16);
    checkOutput("ovf_count", 32'(oOverflowCount), 32'd1);
    uartMode = 0;
    waitQuiet(2500);
    checkOutput("ovf_drain_count", 32'(capByte.size()), 32'(b + 17));
    for (int k = 0; k < 17; k++)
      checkFrame($sformatf("ovf_drain%0d", k), b + k, (k == 0) ? 16'h0050 : 16'(k), 1'b0);

    $display("[TB] stop");
    b    = capByte.size();
    stop = 1'b1;
    applyStimulus(8'h21, 8'h00);
    applyStimulus(8'h22, 8'h00);
    applyStimulus(8'h23, 8'h00);
    tick(1000);
    checkOutput("stop_no_frames", 32'(capByte.size()), 32'(b));
    checkOutput("stop_level", 32'(oFifoLevel), 32'd3);
    checkOutput("stop_idle", 32'(oBusy), 32'd0);
    stop = 1'b0;
    waitQuiet(500);
    checkFrame("stop_f0", b, 16'h0021, 1'b0);
    checkFrame("stop_f1", b + 1, 16'h0022, 1'b0);
    checkFrame("stop_f2", b + 2, 16'h0023, 1'b0);
    checkOutput("proto_errors", 32'(protoErr), 32'd0);

    $display("[TB] issue timeout");
    b        = capByte.size();
    uartMode = 2;
    applyStimulus(8'h44, 8'h00);
    tick(1024);
    checkOutput("to_before_transmit", 32'(uif.uart_transmit), 32'd1);
    checkOutput("to_before_err", 32'(oTimeoutErr), 32'd0);
    tick(1);
    checkOutput("to_after_transmit", 32'(uif.uart_transmit), 32'd0);
    checkOutput("to_after_err", 32'(oTimeoutErr), 32'd1);
    checkOutput("to_after_idle", 32'(oBusy), 32'd0);
    timebinFactor = 8'h09;
    sendTimebin   = 1'b1;
    tick(1100);
    sendTimebin = 1'b0;
    checkOutput("to_tb_retry_busy", 32'(oBusy), 32'd1);
    checkOutput("to_tb_retry_byte", 32'(uif.uart_byte), 32'h09FE);
    uartMode = 0;
    waitQuiet(300);
    checkFrame("to_tb_frame", b, 16'h09FE, 1'b1);
    checkOutput("to_count_lost", 32'(capByte.size()), 32'(b + 1));

    $display("[TB] reset in WAIT_DONE");
    uartMode = 1;
    mode     = 2'd3;
    applyStimulus(8'hAA, 8'hBB);
    applyStimulus(8'hCC, 8'hDD);
    tick(10);
    checkOutput("wd_busy", 32'(oBusy), 32'd1);
    checkOutput("wd_level", 32'(oFifoLevel), 32'd1);
    rst = 1'b1;
    tick(1);
    checkOutput("wd_rst_transmit", 32'(uif.uart_transmit), 32'd0);
    checkOutput("wd_rst_byte", 32'(uif.uart_byte), 32'd0);
    checkOutput("wd_rst_two", 32'(uif.uart_two_bytes), 32'd0);
    checkOutput("wd_rst_level", 32'(oFifoLevel), 32'd0);
    checkOutput("wd_rst_ovf", 32'(oOverflowCount), 32'd0);
    checkOutput("wd_rst_err", 32'(oTimeoutErr), 32'd0);
    checkOutput("wd_rst_busy", 32'(oBusy), 32'd0);
    rst = 1'b0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
